// File: rtl/rll_key_loader.sv
// rll_key_loader: bit-serial key delivery for a random-logic-locked netlist.
// Collects KEY_WIDTH key bits plus one even-parity bit over a valid/ready
// handshake, then drives the real key on key_out only after a parity-correct
// load. Consecutive parity failures are counted; reaching MAX_FAILS enters a
// sticky lockout that only rst clears.
//
// Ports:
//   clk_i-less naming kept as given: clk, rst (async, active-high)
//   load_start  : one-cycle pulse, begins/restarts a load
//   sdi_valid   : serial bit present on sdi
//   sdi         : serial bit, key LSB first, then parity
//   sdi_ready   : block accepts sdi this cycle
//   key_out     : parallel key, bit i feeds keyIn_0_i (decoy unless ACTIVE)
//   key_active  : key_out carries the loaded key
//   load_done   : pulse on parity-correct completion
//   load_err    : pulse on parity mismatch
//   locked_out  : sticky lockout indicator
//   fail_cnt    : consecutive failure count
module rll_key_loader #(
    parameter int unsigned            KEY_WIDTH = 16,
    parameter logic [KEY_WIDTH-1:0]   DECOY_KEY = '0,
    parameter int unsigned            MAX_FAILS = 3,
    parameter int unsigned            FAIL_W    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_start,
    input  logic                 sdi_valid,
    input  logic                 sdi,
    output logic                 sdi_ready,
    output logic [KEY_WIDTH-1:0] key_out,
    output logic                 key_active,
    output logic                 load_done,
    output logic                 load_err,
    output logic                 locked_out,
    output logic [FAIL_W-1:0]    fail_cnt
);

    localparam int unsigned CNT_W = (KEY_WIDTH > 1) ? $clog2(KEY_WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SHIFT   = 3'd1,
        S_PARITY  = 3'd2,
        S_ACTIVE  = 3'd3,
        S_LOCKOUT = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic                   rst_meta_q, rst_sync_q;
    logic [KEY_WIDTH-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   par_q, par_d;
    logic [FAIL_W-1:0]      fail_q, fail_d;
    logic                   sdi_ready_q, sdi_ready_d;
    logic [KEY_WIDTH-1:0]   key_out_q, key_out_d;
    logic                   key_active_q, key_active_d;
    logic                   load_done_q, load_done_d;
    logic                   load_err_q, load_err_d;
    logic                   locked_out_q, locked_out_d;

    logic                   xfer_c;
    logic                   restart_c;
    logic                   last_bit_c;
    logic                   par_ok_c;
    logic [FAIL_W-1:0]      fail_inc_c;

    // Reset asserts asynchronously and releases on a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= 1'b1;
        end else begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= rst_meta_q;
        end
    end

    assign xfer_c     = sdi_valid & sdi_ready_q;
    assign restart_c  = load_start & (state_q != S_LOCKOUT);
    assign last_bit_c = (cnt_q == CNT_W'(KEY_WIDTH - 1));
    assign par_ok_c   = (sdi == par_q);
    assign fail_inc_c = fail_q + FAIL_W'(1);

    // State register.
    always_ff @(posedge clk or posedge rst_sync_q) begin
        if (rst_sync_q) state_q <= S_IDLE;
        else            state_q <= state_d;
    end

    // Next-state logic; load_start has priority over a same-cycle transfer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_ACTIVE: begin
                if (load_start) state_d = S_SHIFT;
            end
            S_SHIFT: begin
                if (load_start)                state_d = S_SHIFT;
                else if (xfer_c && last_bit_c) state_d = S_PARITY;
            end
            S_PARITY: begin
                if (load_start) begin
                    state_d = S_SHIFT;
                end else if (xfer_c) begin
                    if (par_ok_c)                                state_d = S_ACTIVE;
                    else if (fail_inc_c == FAIL_W'(MAX_FAILS))   state_d = S_LOCKOUT;
                    else                                         state_d = S_IDLE;
                end
            end
            S_LOCKOUT: state_d = S_LOCKOUT;
            default:   state_d = S_IDLE;
        endcase
    end

    // Output logic: registered outputs follow the next state so they line up
    // with the state they describe.
    always_comb begin
        sdi_ready_d  = (state_d == S_SHIFT) || (state_d == S_PARITY);
        key_active_d = (state_d == S_ACTIVE);
        locked_out_d = (state_d == S_LOCKOUT);
        load_done_d  = (state_q == S_PARITY) && !load_start && xfer_c && par_ok_c;
        load_err_d   = (state_q == S_PARITY) && !load_start && xfer_c && !par_ok_c;
        key_out_d    = DECOY_KEY;
        if (state_d == S_ACTIVE) begin
            key_out_d = (state_q == S_PARITY) ? shift_q : key_out_q;
        end
    end

    // Datapath next values: shift register, bit counter, parity, fail counter.
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        par_d   = par_q;
        fail_d  = fail_q;
        if (restart_c) begin
            shift_d = '0;
            cnt_d   = '0;
            par_d   = 1'b0;
        end else if (xfer_c && (state_q == S_SHIFT)) begin
            shift_d[cnt_q] = sdi;
            par_d          = par_q ^ sdi;
            cnt_d          = last_bit_c ? '0 : cnt_q + CNT_W'(1);
        end else if (xfer_c && (state_q == S_PARITY)) begin
            if (par_ok_c)                          fail_d = '0;
            else if (fail_q < FAIL_W'(MAX_FAILS))  fail_d = fail_inc_c;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst_sync_q) begin
        if (rst_sync_q) begin
            shift_q      <= '0;
            cnt_q        <= '0;
            par_q        <= 1'b0;
            fail_q       <= '0;
            sdi_ready_q  <= 1'b0;
            key_out_q    <= DECOY_KEY;
            key_active_q <= 1'b0;
            load_done_q  <= 1'b0;
            load_err_q   <= 1'b0;
            locked_out_q <= 1'b0;
        end else begin
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            par_q        <= par_d;
            fail_q       <= fail_d;
            sdi_ready_q  <= sdi_ready_d;
            key_out_q    <= key_out_d;
            key_active_q <= key_active_d;
            load_done_q  <= load_done_d;
            load_err_q   <= load_err_d;
            locked_out_q <= locked_out_d;
        end
    end

    assign sdi_ready  = sdi_ready_q;
    assign key_out    = key_out_q;
    assign key_active = key_active_q;
    assign load_done  = load_done_q;
    assign load_err   = load_err_q;
    assign locked_out = locked_out_q;
    assign fail_cnt   = fail_q;

endmodule
